// File: rtl/mem_wait_model_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wait_model_if
//  Description : Request/ready bus between the processor data port and the
//                wait-state data memory model.
//                Master side (core): req, wr_en, addr, wdata, wmask.
//                Slave side (memory): rdata, ready, busy, err, rd_count,
//                wr_count.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_wait_model_if #(
    parameter int DATA_W = 64,
    parameter int MASK_W = 8,
    parameter int ADDR_W = 29
) ();

    logic              req;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              busy;
    logic              err;
    logic [31:0]       rd_count;
    logic [31:0]       wr_count;

    modport master (
        output req, wr_en, addr, wdata, wmask,
        input  rdata, ready, busy, err, rd_count, wr_count
    );

    modport slave (
        input  req, wr_en, addr, wdata, wmask,
        output rdata, ready, busy, err, rd_count, wr_count
    );

endinterface
`default_nettype wire

// File: rtl/mem_wait_model.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wait_model
//  Description : Byte-masked data memory with a fixed number of wait states
//                behind a request/ready handshake. Used in place of the
//                zero-latency data memory so the core's stall logic sees a
//                slow memory. Out-of-range accesses are flagged with err and
//                completed reads/writes are counted (saturating).
//  Ports       : clk   - rising-edge clock
//                nrst  - asynchronous active-low reset
//                bus   - mem_wait_model_if.slave (request in, response out)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_wait_model #(
    parameter int DATA_W  = 64,
    parameter int MASK_W  = 8,
    parameter int DEPTH   = 512,
    parameter int ADDR_W  = 29,
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                nrst,
    mem_wait_model_if.slave     bus
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $fatal(1, "mem_wait_model: LATENCY=%0d outside legal range 1..15", LATENCY);
        end
        if ((DATA_W % 8) != 0 || MASK_W != DATA_W / 8) begin : g_bad_mask
            $fatal(1, "mem_wait_model: DATA_W=%0d / MASK_W=%0d mismatch", DATA_W, MASK_W);
        end
        if (DEPTH < 2) begin : g_bad_depth
            $fatal(1, "mem_wait_model: DEPTH=%0d must be at least 2", DEPTH);
        end
    endgenerate

    localparam int         c_idx_w    = $clog2(DEPTH);
    localparam logic [3:0] c_cnt_init = 4'(LATENCY - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    // ------------------------------------------------------------------
    // State and captured request
    // ------------------------------------------------------------------
    logic [0:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [MASK_W-1:0] r_wmask;

    logic [DATA_W-1:0] r_rdata;
    logic              r_ready;
    logic              r_err;
    logic [31:0]       r_rd_count;
    logic [31:0]       r_wr_count;

    // Storage is deliberately left out of reset so it behaves like a RAM.
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic               w_complete;
    logic               w_in_range;
    logic [c_idx_w-1:0] w_index;
    logic [DATA_W-1:0]  w_rd_word;
    logic [DATA_W-1:0]  w_merged;

    assign w_complete = (r_state == S_WAIT) && (r_cnt == 4'd0);
    // Compared at 64 bits so a DEPTH equal to 2**ADDR_W does not wrap.
    assign w_in_range = (64'(r_addr) < 64'(DEPTH));
    assign w_index    = r_addr[c_idx_w-1:0];
    assign w_rd_word  = r_mem[w_index];

    // Byte-lane merge of captured write data over the current word.
    generate
        for (genvar i = 0; i < MASK_W; i++) begin : g_byte
            assign w_merged[8*i +: 8] = r_wmask[i] ? r_wdata[8*i +: 8]
                                                   : w_rd_word[8*i +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake FSM, response registers and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_wr_en    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wmask    <= '0;
            r_rdata    <= '0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_rd_count <= 32'd0;
            r_wr_count <= 32'd0;
        end else begin
            // ready and err are single-cycle pulses on the completion edge.
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_wr_en <= bus.wr_en;
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        r_wmask <= bus.wmask;
                        r_cnt   <= c_cnt_init;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_err   <= !w_in_range;
                        if (!w_in_range) begin
                            r_rdata <= '0;
                        end else if (r_wr_en) begin
                            // Write-through: respond with the merged word.
                            r_rdata <= w_merged;
                            if (r_wr_count != 32'hFFFF_FFFF) begin
                                r_wr_count <= r_wr_count + 32'd1;
                            end
                        end else begin
                            r_rdata <= w_rd_word;
                            if (r_rd_count != 32'hFFFF_FFFF) begin
                                r_rd_count <= r_rd_count + 32'd1;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Memory write on the completion edge. A reset during the wait phase
    // returns the FSM to idle, so an aborted write never reaches here.
    always_ff @(posedge clk) begin
        if (w_complete && w_in_range && r_wr_en) begin
            r_mem[w_index] <= w_merged;
        end
    end

    assign bus.rdata    = r_rdata;
    assign bus.ready    = r_ready;
    assign bus.busy     = (r_state == S_WAIT);
    assign bus.err      = r_err;
    assign bus.rd_count = r_rd_count;
    assign bus.wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_wait_model.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wait_model
//  Description : Self-checking bench for mem_wait_model. Three instances run
//                with LATENCY 2, 1 and 15; one is addressed at a time. A
//                word-level reference model predicts response data, err,
//                counters and the completion cycle.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_wait_model;

    localparam int DATA_W     = 64;
    localparam int MASK_W     = 8;
    localparam int DEPTH      = 512;
    localparam int ADDR_W     = 29;
    localparam int N_DUT      = 3;
    localparam int INIT_WORDS = 32;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    int                r_sel   = 0;
    logic              r_req   = 1'b0;
    logic              r_wr_en = 1'b0;
    logic [ADDR_W-1:0] r_addr  = '0;
    logic [DATA_W-1:0] r_wdata = '0;
    logic [MASK_W-1:0] r_wmask = '0;

    logic [DATA_W-1:0] w_rdata    [N_DUT];
    logic              w_ready    [N_DUT];
    logic              w_busy     [N_DUT];
    logic              w_err      [N_DUT];
    logic [31:0]       w_rd_count [N_DUT];
    logic [31:0]       w_wr_count [N_DUT];

    generate
        for (genvar k = 0; k < N_DUT; k++) begin : g_dut
            mem_wait_model_if #(.DATA_W(DATA_W), .MASK_W(MASK_W), .ADDR_W(ADDR_W)) bus ();

            assign bus.req   = r_req && (r_sel == k);
            assign bus.wr_en = r_wr_en;
            assign bus.addr  = r_addr;
            assign bus.wdata = r_wdata;
            assign bus.wmask = r_wmask;

            mem_wait_model #(
                .DATA_W (DATA_W),
                .MASK_W (MASK_W),
                .DEPTH  (DEPTH),
                .ADDR_W (ADDR_W),
                .LATENCY((k == 0) ? 2 : (k == 1) ? 1 : 15)
            ) u_dut (
                .clk (clk),
                .nrst(nrst),
                .bus (bus)
            );

            assign w_rdata[k]    = bus.rdata;
            assign w_ready[k]    = bus.ready;
            assign w_busy[k]     = bus.busy;
            assign w_err[k]      = bus.err;
            assign w_rd_count[k] = bus.rd_count;
            assign w_wr_count[k] = bus.wr_count;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Reference model: plain word array plus counters per instance
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mdl_mem [N_DUT][DEPTH];
    logic [31:0]       mdl_rd  [N_DUT];
    logic [31:0]       mdl_wr  [N_DUT];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 15;
    endfunction

    task automatic model_access(input int k, input logic wr, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m,
                                output logic [DATA_W-1:0] exp_rdata, output logic exp_err);
        logic [DATA_W-1:0] word;
        if (a >= DEPTH) begin
            exp_err   = 1'b1;
            exp_rdata = '0;
        end else begin
            exp_err = 1'b0;
            word    = mdl_mem[k][a];
            if (wr) begin
                for (int b = 0; b < MASK_W; b++)
                    if (m[b]) word[8*b +: 8] = d[8*b +: 8];
                mdl_mem[k][a] = word;
                if (mdl_wr[k] != 32'hFFFF_FFFF) mdl_wr[k] = mdl_wr[k] + 1;
            end else begin
                if (mdl_rd[k] != 32'hFFFF_FFFF) mdl_rd[k] = mdl_rd[k] + 1;
            end
            exp_rdata = word;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks busy high / ready low for the LATENCY cycles after acceptance,
    // leaving the caller at the negedge following the completion edge.
    task automatic wait_phase(input int k);
        for (int c = 0; c < lat_of(k); c++) begin
            chk($sformatf("busy_L%0d_c%0d", lat_of(k), c),
                64'({w_busy[k], w_ready[k]}), 64'(2'b10));
            @(negedge clk);
        end
    endtask

    task automatic chk_done(input int k, input logic [DATA_W-1:0] er, input logic ee);
        chk($sformatf("ready_L%0d", lat_of(k)),
            64'({w_busy[k], w_ready[k], w_err[k]}), 64'({1'b0, 1'b1, ee}));
        chk($sformatf("rdata_L%0d", lat_of(k)), w_rdata[k], er);
        chk($sformatf("rd_count_L%0d", lat_of(k)), 64'(w_rd_count[k]), 64'(mdl_rd[k]));
        chk($sformatf("wr_count_L%0d", lat_of(k)), 64'(w_wr_count[k]), 64'(mdl_wr[k]));
    endtask

    // One access with req dropped after acceptance and inputs scrambled
    // while in flight.
    task automatic access(input int k, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
        logic [DATA_W-1:0] er;
        logic              ee;
        @(negedge clk);
        r_sel = k; r_req = 1'b1; r_wr_en = wr; r_addr = a; r_wdata = d; r_wmask = m;
        model_access(k, wr, a, d, m, er, ee);
        @(negedge clk);
        r_req = 1'b0; r_wr_en = ~wr; r_addr = ADDR_W'($urandom);
        r_wdata = {$urandom, $urandom}; r_wmask = MASK_W'($urandom);
        wait_phase(k);
        chk_done(k, er, ee);
        @(negedge clk);
        chk($sformatf("pulse_end_L%0d", lat_of(k)),
            64'({w_ready[k], w_err[k]}), 64'(2'b00));
        chk($sformatf("rdata_hold_L%0d", lat_of(k)), w_rdata[k], er);
    endtask

    // Two reads with req held high throughout; the second must complete
    // exactly LATENCY+1 cycles after the first.
    task automatic held_pair(input int k, input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
        logic [DATA_W-1:0] er;
        logic              ee;
        @(negedge clk);
        r_sel = k; r_req = 1'b1; r_wr_en = 1'b0; r_addr = a1; r_wmask = '1;
        model_access(k, 1'b0, a1, '0, '0, er, ee);
        @(negedge clk);
        r_wr_en = 1'b1; r_addr = a2; r_wdata = {$urandom, $urandom};
        wait_phase(k);
        chk_done(k, er, ee);
        r_wr_en = 1'b0; r_addr = a2;
        model_access(k, 1'b0, a2, '0, '0, er, ee);
        @(negedge clk);
        r_wr_en = 1'b1; r_addr = a1; r_wdata = {$urandom, $urandom};
        wait_phase(k);
        chk_done(k, er, ee);
        r_req = 1'b0;
        @(negedge clk);
        chk($sformatf("held_stop_L%0d", lat_of(k)),
            64'({w_busy[k], w_ready[k]}), 64'(2'b00));
    endtask

    // Reset pulled half a cycle after a write is accepted: no completion,
    // no memory change, counters cleared everywhere.
    task automatic reset_abort(input int k, input logic [ADDR_W-1:0] a);
        @(negedge clk);
        r_sel = k; r_req = 1'b1; r_wr_en = 1'b1; r_addr = a;
        r_wdata = 64'hDEAD_BEEF_CAFE_F00D; r_wmask = '1;
        @(negedge clk);
        r_req = 1'b0;
        nrst  = 1'b0;
        #1;
        for (int j = 0; j < N_DUT; j++) begin
            chk($sformatf("rst_outs_%0d", j),
                64'({w_busy[j], w_ready[j], w_err[j]}), 64'(3'b000));
            chk($sformatf("rst_counts_%0d", j),
                {w_rd_count[j], w_wr_count[j]}, 64'd0);
            mdl_rd[j] = 32'd0;
            mdl_wr[j] = 32'd0;
        end
        @(negedge clk);
        nrst = 1'b1;
        for (int c = 0; c < lat_of(k) + 2; c++) begin
            @(negedge clk);
            chk("abort_no_ready", 64'({w_busy[k], w_ready[k]}), 64'(2'b00));
        end
        access(k, 1'b0, a, '0, '0);
    endtask

    initial begin
        logic [ADDR_W-1:0] ra;

        for (int k = 0; k < N_DUT; k++) begin
            mdl_rd[k] = 32'd0;
            mdl_wr[k] = 32'd0;
            for (int a = 0; a < DEPTH; a++) mdl_mem[k][a] = '0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        for (int k = 0; k < N_DUT; k++) begin
            chk($sformatf("reset_flags_%0d", k),
                64'({w_busy[k], w_ready[k], w_err[k]}), 64'(3'b000));
            chk($sformatf("reset_rdata_%0d", k), w_rdata[k], 64'd0);
            chk($sformatf("reset_counts_%0d", k), {w_rd_count[k], w_wr_count[k]}, 64'd0);
        end
        nrst = 1'b1;

        for (int k = 0; k < N_DUT; k++) begin
            // Bring the region used below to a known zero state.
            for (int a = 0; a < INIT_WORDS; a++) access(k, 1'b1, ADDR_W'(a), '0, '1);
            access(k, 1'b1, ADDR_W'(88), '0, '1);

            // Full write, read back, partial write, read back, empty mask
            access(k, 1'b1, ADDR_W'(5), 64'h1122334455667788, 8'hFF);
            access(k, 1'b0, ADDR_W'(5), '0, '0);
            access(k, 1'b1, ADDR_W'(5), 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
            access(k, 1'b0, ADDR_W'(5), '0, '0);
            chk($sformatf("merged_L%0d", lat_of(k)), w_rdata[k], 64'h11223344AAAAAAAA);
            access(k, 1'b1, ADDR_W'(5), 64'h5555_5555_5555_5555, 8'h00);
            access(k, 1'b0, ADDR_W'(5), '0, '0);

            // Out of range; 600 must not alias onto 88
            access(k, 1'b0, ADDR_W'(600), '0, '0);
            access(k, 1'b1, ADDR_W'(600), 64'hFFFF_0000_FFFF_0000, 8'hFF);
            access(k, 1'b0, ADDR_W'(88), '0, '0);
            access(k, 1'b1, ADDR_W'(DEPTH), 64'h0123_4567_89AB_CDEF, 8'hFF);
            access(k, 1'b0, ADDR_W'(DEPTH - 1), '0, '0);

            // Back-to-back with req held high
            held_pair(k, ADDR_W'(5), ADDR_W'(7));

            // Randomized traffic
            for (int n = 0; n < 40; n++) begin
                if ($urandom_range(0, 7) == 0)
                    ra = ADDR_W'($urandom_range(DEPTH, (1 << ADDR_W) - 1));
                else
                    ra = ADDR_W'($urandom_range(0, INIT_WORDS - 1));
                access(k, 1'($urandom), ra, {$urandom, $urandom}, MASK_W'($urandom));
            end
        end

        // Reset abort on the slower instances
        reset_abort(0, ADDR_W'(3));
        reset_abort(2, ADDR_W'(9));

        // Counter saturation
        @(negedge clk);
        force g_dut[0].u_dut.r_rd_count = 32'hFFFF_FFFE;
        force g_dut[0].u_dut.r_wr_count = 32'hFFFF_FFFF;
        #1;
        release g_dut[0].u_dut.r_rd_count;
        release g_dut[0].u_dut.r_wr_count;
        mdl_rd[0] = 32'hFFFF_FFFE;
        mdl_wr[0] = 32'hFFFF_FFFF;
        access(0, 1'b0, ADDR_W'(5), '0, '0);
        access(0, 1'b0, ADDR_W'(6), '0, '0);
        chk("rd_sat", 64'(w_rd_count[0]), 64'(32'hFFFF_FFFF));
        access(0, 1'b1, ADDR_W'(6), 64'h0F0F_0F0F_0F0F_0F0F, 8'h3C);
        chk("wr_sat", 64'(w_wr_count[0]), 64'(32'hFFFF_FFFF));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
